// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, imem req/ack handshake, one-entry skid, redirects.
// Optional IFETCH_PERF_EN adds perf_fetch/perf_stall/perf_flush counters.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
`ifdef IFETCH_PERF_EN
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush,
`endif
    output logic [31:0] pco,
    output logic [31:0] inst,
    output logic        inst_valid
);

    typedef enum logic [1:0] {START, FETCH, HOLD, FLUSH} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] skid_pc;
    logic [31:0] skid_inst;
    logic        skid_valid;
    logic        slot_free;
    logic [31:0] pc_next;

    assign slot_free = !inst_valid || !stall;
    assign pc_next   = pc + PC_STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= START;
            pc         <= RESET_PC;
            imem_addr  <= RESET_PC;
            imem_req   <= 1'b0;
            pco        <= '0;
            inst       <= '0;
            inst_valid <= 1'b0;
            skid_pc    <= '0;
            skid_inst  <= '0;
            skid_valid <= 1'b0;
        end else begin
            unique case (state)
                START: begin
                    imem_req <= 1'b1;
                    state    <= FETCH;
                    if (br_taken) begin
                        pc         <= br_target;
                        imem_addr  <= br_target;
                        inst_valid <= 1'b0;
                        skid_valid <= 1'b0;
                    end else begin
                        imem_addr <= pc;
                    end
                end
                FETCH: begin
                    if (br_taken) begin
                        pc         <= br_target;
                        inst_valid <= 1'b0;
                        skid_valid <= 1'b0;
                        if (imem_ack) imem_addr <= br_target;
                        else          state     <= FLUSH;
                    end else if (imem_ack) begin
                        pc <= pc_next;
                        if (slot_free) begin
                            pco        <= imem_addr;
                            inst       <= imem_rdata;
                            inst_valid <= 1'b1;
                            imem_addr  <= pc_next;
                        end else begin
                            skid_pc    <= imem_addr;
                            skid_inst  <= imem_rdata;
                            skid_valid <= 1'b1;
                            imem_req   <= 1'b0;
                            state      <= HOLD;
                        end
                    end else if (slot_free && inst_valid) begin
                        inst_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (br_taken) begin
                        pc         <= br_target;
                        imem_addr  <= br_target;
                        inst_valid <= 1'b0;
                        skid_valid <= 1'b0;
                        imem_req   <= 1'b1;
                        state      <= FETCH;
                    end else if (!stall) begin
                        pco        <= skid_pc;
                        inst       <= skid_inst;
                        inst_valid <= 1'b1;
                        skid_valid <= 1'b0;
                        imem_req   <= 1'b1;
                        imem_addr  <= pc;
                        state      <= FETCH;
                    end
                end
                FLUSH: begin
                    // Squashed request must still complete before reissuing
                    if (br_taken) begin
                        pc         <= br_target;
                        inst_valid <= 1'b0;
                        skid_valid <= 1'b0;
                    end
                    if (imem_ack) begin
                        imem_addr <= br_taken ? br_target : pc;
                        state     <= FETCH;
                    end
                end
                default: state <= START;
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch <= '0;
            perf_stall <= '0;
            perf_flush <= '0;
        end else begin
            if (state == FETCH && imem_ack && !br_taken)
                perf_fetch <= perf_fetch + 32'd1;
            if (state == HOLD)
                perf_stall <= perf_stall + 32'd1;
            if (br_taken)
                perf_flush <= perf_flush + 32'd1;
        end
    end
`endif

endmodule
